// File: rtl/var1_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// var1_sweep_ctrl
//   Sequencer for an N_IN-input combinational function unit. A start pulse
//   (taken only while idle) sweeps every input code 0..2^N_IN-1 in ascending
//   order. Each code is held for SETTLE_CYCLES cycles. The unit's output is
//   sampled on the last cycle of each code, and the samples build the truth
//   table and a count of ones.
//
// Parameters
//   N_IN          function input width; the table holds 2^N_IN entries
//   SETTLE_CYCLES cycles each code is held before it is sampled (>= 1)
//
// Ports
//   clk          in   1         system clock, rising edge
//   rst          in   1         synchronous, active-high reset
//   start        in   1         begin a sweep; ignored while busy
//   func_in      out  N_IN      registered code driven to the function unit
//   func_out     in   1         function unit output
//   busy         out  1         sweep in progress
//   done         out  1         one-cycle pulse: the results are valid
//   truth_table  out  2^N_IN    bit i = f(i); held until the next accepted start
//   ones_count   out  N_IN+1    number of 1 bits in truth_table
//
// Optional feature (macro SWEEP_CHECK_EN):
//   expected     in   2^N_IN    golden table; held stable while busy
//   mismatch     out  1         sticky: some sample differed from expected
//   mismatch_idx out  N_IN      code of the first mismatch; 0 if none
// ---------------------------------------------------------------------------
module var1_sweep_ctrl #(
    parameter int unsigned N_IN          = 5,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        func_in,
    input  logic                   func_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   truth_table,
    output logic [N_IN:0]          ones_count
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic                   mismatch,
    output logic [N_IN-1:0]        mismatch_idx
`endif
);

    localparam int unsigned TT_W  = 1 << N_IN;
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [TT_W-1:0]   tt_q,    tt_d;
    logic [N_IN:0]     ones_q,  ones_d;
`ifdef SWEEP_CHECK_EN
    logic              mm_q,     mm_d;
    logic [N_IN-1:0]   mm_idx_q, mm_idx_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tt_d    = tt_q;
        ones_d  = ones_q;
`ifdef SWEEP_CHECK_EN
        mm_d     = mm_q;
        mm_idx_d = mm_idx_q;
`endif

        case (state_q)
            IDLE: begin
                // Also reached in the done cycle, so a start there is accepted.
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    tt_d    = '0;
                    ones_d  = '0;
`ifdef SWEEP_CHECK_EN
                    mm_d     = 1'b0;
                    mm_idx_d = '0;
`endif
                end
            end

            RUN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    // Last settle cycle of this code: capture the unit's output.
                    tt_d[idx_q] = func_out;
                    ones_d      = ones_q + (N_IN+1)'(func_out);
                    cnt_d       = '0;
`ifdef SWEEP_CHECK_EN
                    if ((func_out != expected[idx_q]) && !mm_q) begin
                        mm_d     = 1'b1;
                        mm_idx_d = idx_q;
                    end
`endif
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
            ones_q  <= '0;
`ifdef SWEEP_CHECK_EN
            mm_q     <= 1'b0;
            mm_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
`ifdef SWEEP_CHECK_EN
            mm_q     <= mm_d;
            mm_idx_q <= mm_idx_d;
`endif
        end
    end

    assign func_in     = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign ones_count  = ones_q;
`ifdef SWEEP_CHECK_EN
    assign mismatch     = mm_q;
    assign mismatch_idx = mm_idx_q;
`endif

endmodule

// File: tb/tb_var1_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_var1_sweep_ctrl
//   Directed bench for var1_sweep_ctrl. There are two instances: one with
//   SETTLE_CYCLES=1 and one with SETTLE_CYCLES=3. Each function unit is
//   modelled as a lookup in a bench-owned truth-table mask. When
//   SWEEP_CHECK_EN is defined, the mismatch ports are connected and checked.
// ---------------------------------------------------------------------------
module tb_var1_sweep_ctrl;

    localparam logic [31:0] GOLDEN = 32'hF1F1F10E;  // var1 function, 18 ones

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [4:0]  func_in_a, func_in_b;
    logic        func_out_a, func_out_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [31:0] tt_a, tt_b;
    logic [5:0]  ones_a, ones_b;
    logic [31:0] fmask_a, fmask_b;
`ifdef SWEEP_CHECK_EN
    logic [31:0] exp_a, exp_b;
    logic        mm_a, mm_b;
    logic [4:0]  mm_idx_a, mm_idx_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign func_out_a = fmask_a[func_in_a];
    assign func_out_b = fmask_b[func_in_b];

    var1_sweep_ctrl #(.N_IN(5), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .func_in(func_in_a), .func_out(func_out_a),
        .busy(busy_a), .done(done_a),
        .truth_table(tt_a), .ones_count(ones_a)
`ifdef SWEEP_CHECK_EN
        , .expected(exp_a), .mismatch(mm_a), .mismatch_idx(mm_idx_a)
`endif
    );

    var1_sweep_ctrl #(.N_IN(5), .SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .func_in(func_in_b), .func_out(func_out_b),
        .busy(busy_b), .done(done_b),
        .truth_table(tt_b), .ones_count(ones_b)
`ifdef SWEEP_CHECK_EN
        , .expected(exp_b), .mismatch(mm_b), .mismatch_idx(mm_idx_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // On entry, start has just been sampled and the bench is in busy cycle 1.
    // The task returns in the cycle where done is seen, or on timeout (done_cyc=0).
    task automatic sweep_a(input int pulse_at, output int done_cyc,
                           output int busy_n, output int seq_err);
        done_cyc = 0; busy_n = 0; seq_err = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (done_a) begin
                done_cyc = cyc;
                break;
            end
            if (busy_a) busy_n++;
            if (func_in_a !== 5'((cyc - 1) % 32)) seq_err++;
            if (cyc == pulse_at) start_a = 1'b1;
            tick();
            start_a = 1'b0;
        end
    endtask

    task automatic sweep_b(output int done_cyc, output int busy_n, output int seq_err);
        done_cyc = 0; busy_n = 0; seq_err = 0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (done_b) begin
                done_cyc = cyc;
                break;
            end
            if (busy_b) busy_n++;
            if (func_in_b !== 5'(((cyc - 1) / 3) % 32)) seq_err++;
            tick();
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        int dc, bn, se;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        fmask_a = GOLDEN; fmask_b = GOLDEN;
`ifdef SWEEP_CHECK_EN
        exp_a = GOLDEN; exp_b = GOLDEN;
`endif
        tick(); tick();

        // Reset state
        check("rst_busy",    64'(busy_a),    64'd0);
        check("rst_done",    64'(done_a),    64'd0);
        check("rst_func_in", 64'(func_in_a), 64'd0);
        check("rst_tt",      64'(tt_a),      64'd0);
        check("rst_ones",    64'(ones_a),    64'd0);
        rst = 1'b0;
        tick();

        // 1: basic sweep, SETTLE=1
        pulse_start_a();
        sweep_a(0, dc, bn, se);
        check("t1_done_cyc", 64'(dc),     64'd33);
        check("t1_busy_n",   64'(bn),     64'd32);
        check("t1_seq",      64'(se),     64'd0);
        check("t1_tt",       64'(tt_a),   64'hF1F1F10E);
        check("t1_ones",     64'(ones_a), 64'd18);
        check("t1_busy_off", 64'(busy_a), 64'd0);
        tick();
        check("t1_done_1cyc", 64'(done_a),    64'd0);
        check("t1_idle_fin",  64'(func_in_a), 64'd0);

        // 2: SETTLE=3
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        sweep_b(dc, bn, se);
        check("t2_done_cyc", 64'(dc),     64'd97);
        check("t2_busy_n",   64'(bn),     64'd96);
        check("t2_seq",      64'(se),     64'd0);
        check("t2_tt",       64'(tt_b),   64'hF1F1F10E);
        check("t2_ones",     64'(ones_b), 64'd18);
        tick();
        check("t2_done_1cyc", 64'(done_b), 64'd0);

        // 3: start re-pulsed at busy cycle 10 is ignored
        pulse_start_a();
        sweep_a(10, dc, bn, se);
        check("t3_done_cyc", 64'(dc),     64'd33);
        check("t3_busy_n",   64'(bn),     64'd32);
        check("t3_seq",      64'(se),     64'd0);
        check("t3_tt",       64'(tt_a),   64'hF1F1F10E);
        check("t3_ones",     64'(ones_a), 64'd18);
        tick();
        check("t3_no_restart", 64'(busy_a), 64'd0);

        // 4: reset in busy cycle 17
        pulse_start_a();
        for (int c = 1; c < 17; c++) tick();
        check("t4_busy_pre", 64'(busy_a),    64'd1);
        check("t4_fin_pre",  64'(func_in_a), 64'd16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy",    64'(busy_a),    64'd0);
        check("t4_func_in", 64'(func_in_a), 64'd0);
        check("t4_tt",      64'(tt_a),      64'd0);
        check("t4_ones",    64'(ones_a),    64'd0);
        check("t4_done",    64'(done_a),    64'd0);
        tick();
        check("t4_stay_idle", 64'(busy_a), 64'd0);
        pulse_start_a();
        sweep_a(0, dc, bn, se);
        check("t4_re_done_cyc", 64'(dc),     64'd33);
        check("t4_re_tt",       64'(tt_a),   64'hF1F1F10E);
        check("t4_re_ones",     64'(ones_a), 64'd18);
        tick();

        // 5: func_out tied high, then start in the done cycle
        fmask_a = '1;
        pulse_start_a();
        sweep_a(0, dc, bn, se);
        check("t5_done_cyc", 64'(dc),     64'd33);
        check("t5_tt",       64'(tt_a),   64'hFFFFFFFF);
        check("t5_ones",     64'(ones_a), 64'd32);
        pulse_start_a();
        check("t5_restart_busy", 64'(busy_a),    64'd1);
        check("t5_restart_tt",   64'(tt_a),      64'd0);
        check("t5_restart_ones", 64'(ones_a),    64'd0);
        check("t5_restart_done", 64'(done_a),    64'd0);
        check("t5_restart_fin",  64'(func_in_a), 64'd0);
        sweep_a(0, dc, bn, se);
        check("t5b_done_cyc", 64'(dc),     64'd33);
        check("t5b_ones",     64'(ones_a), 64'd32);
        tick();
        fmask_a = GOLDEN;

`ifdef SWEEP_CHECK_EN
        // 6: golden comparison
        exp_a = GOLDEN ^ 32'h0000_0020;
        pulse_start_a();
        sweep_a(0, dc, bn, se);
        check("t6_done_cyc", 64'(dc),       64'd33);
        check("t6_mm",       64'(mm_a),     64'd1);
        check("t6_mm_idx",   64'(mm_idx_a), 64'd5);
        tick();
        exp_a = GOLDEN;
        pulse_start_a();
        check("t6_clr_mm", 64'(mm_a), 64'd0);
        sweep_a(0, dc, bn, se);
        check("t6x_mm",     64'(mm_a),     64'd0);
        check("t6x_mm_idx", 64'(mm_idx_a), 64'd0);
        tick();
        exp_a = GOLDEN ^ 32'h8000_0001;
        pulse_start_a();
        sweep_a(0, dc, bn, se);
        check("t6f_mm",     64'(mm_a),     64'd1);
        check("t6f_mm_idx", 64'(mm_idx_a), 64'd0);
        check("t6_b_mm",    64'(mm_b),     64'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
